// File: rtl/mux_scan_n.sv
// mux_scan_n: N:1 multiplexer (WIDTH bits per channel) with a registered output
// and two modes.
//   mode=0 (manual): sel picks the channel.
//   mode=1 (scan)  : an internal sequencer steps through the channels and holds
//                    each one for DWELL cycles. y tracks the live data of the
//                    channel it currently holds.
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   in           N*WIDTH channel bus, channel k = in[k*WIDTH +: WIDTH]
//   sel          manual channel select
//   mode         0 = manual, 1 = scan
//   y            registered data of channel ch
//   ch           channel index carried by y
//   y_valid      y holds real channel data
//   wrap         1-cycle pulse when the scan restarts from a lower channel
//   ch_en        channel enable mask (only when MUX_SCAN_SKIP_EN is defined)
// Build option: define MUX_SCAN_SKIP_EN to add ch_en. The scan then skips
// disabled channels, and a manual select of a disabled channel behaves like an
// out-of-range select.
module mux_scan_n #(
    parameter int N     = 8,
    parameter int WIDTH = 8,
    parameter int DWELL = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in,
    input  logic [SEL_W-1:0]   sel,
    input  logic               mode,
    output logic [WIDTH-1:0]   y,
    output logic [SEL_W-1:0]   ch,
    output logic               y_valid,
    output logic               wrap
`ifdef MUX_SCAN_SKIP_EN
    ,
    input  logic [N-1:0]       ch_en
`endif
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic {MANUAL, SCAN} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [N-1:0]     en;
    logic             sel_ok;
    logic [SEL_W-1:0] nxt;
    logic [WIDTH-1:0] d_sel, d_cur, d_nxt;

`ifdef MUX_SCAN_SKIP_EN
    assign en = ch_en;
`else
    assign en = '1;
`endif

    // Data of channel idx; indices >= N give zero (they are never used).
    function automatic logic [WIDTH-1:0] pick(input logic [N*WIDTH-1:0] bus,
                                              input logic [SEL_W-1:0]   idx);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++)
            if (idx == SEL_W'(k)) r = bus[k*WIDTH +: WIDTH];
        return r;
    endfunction

    // Next enabled channel above c, wrapping around. Walking the offsets from
    // large to small lets the nearest enabled channel win. If no other channel
    // is enabled, the result is c itself.
    function automatic logic [SEL_W-1:0] next_en(input logic [SEL_W-1:0] c,
                                                 input logic [N-1:0]     m);
        logic [SEL_W-1:0] r;
        int               idx;
        r = c;
        for (int k = N - 1; k >= 1; k--) begin
            idx = (int'(c) + k) % N;
            if (m[idx]) r = SEL_W'(idx);
        end
        return r;
    endfunction

    always_comb begin
        sel_ok = 1'b0;
        for (int k = 0; k < N; k++)
            if (sel == SEL_W'(k) && en[k]) sel_ok = 1'b1;
        nxt   = next_en(ch, en);
        d_sel = pick(in, sel);
        d_cur = pick(in, ch);
        d_nxt = pick(in, nxt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= MANUAL;
            cnt     <= '0;
            y       <= '0;
            ch      <= '0;
            y_valid <= 1'b0;
            wrap    <= 1'b0;
        end else if (!mode) begin
            state <= MANUAL;
            cnt   <= '0;
            wrap  <= 1'b0;
            if (sel_ok) begin
                y       <= d_sel;
                ch      <= sel;
                y_valid <= 1'b1;
            end else begin
                // ch keeps the last valid index so a later scan has a start point
                y       <= '0;
                y_valid <= 1'b0;
            end
        end else begin
            state <= SCAN;
            if (en == '0) begin
                // nothing to scan: freeze position and data, flag invalid
                y_valid <= 1'b0;
                wrap    <= 1'b0;
            end else if (!en[ch] || (state == SCAN && cnt == CNT_W'(DWELL - 1))) begin
                ch      <= nxt;
                y       <= d_nxt;
                y_valid <= 1'b1;
                wrap    <= (nxt <= ch);
                cnt     <= '0;
            end else begin
                // The entry edge shows the current ch with the counter at zero,
                // so the first channel also gets a full DWELL-cycle hold.
                y       <= d_cur;
                y_valid <= 1'b1;
                wrap    <= 1'b0;
                cnt     <= (state == SCAN) ? cnt + 1'b1 : '0;
            end
        end
    end

endmodule

// File: tb/tb_mux_scan_n.sv
module tb_mux_scan_n;
    localparam int DW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst  = 1'b1;
    logic       mode = 1'b0;
    logic [2:0] sel  = 3'd0;
    logic [7:0] dat [8];
    logic [63:0] din;

    logic [7:0] ya, yb;
    logic [2:0] cha, chb;
    logic       va, vb, wa, wb;

    always_comb
        for (int k = 0; k < 8; k++) din[k*8 +: 8] = dat[k];

    mux_scan_n #(.N(8), .WIDTH(8), .DWELL(DW)) dut_a (
        .clk(clk), .rst(rst), .in(din), .sel(sel), .mode(mode),
        .y(ya), .ch(cha), .y_valid(va), .wrap(wa)
`ifdef MUX_SCAN_SKIP_EN
        , .ch_en(8'hFF)
`endif
    );

    mux_scan_n #(.N(6), .WIDTH(8), .DWELL(DW)) dut_b (
        .clk(clk), .rst(rst), .in(din[47:0]), .sel(sel), .mode(mode),
        .y(yb), .ch(chb), .y_valid(vb), .wrap(wb)
`ifdef MUX_SCAN_SKIP_EN
        , .ch_en(6'h3F)
`endif
    );

    // Reference: age = how many output cycles the current scan channel has been shown.
    typedef struct {int y; int ch; int vld; int wrap; int age; bit scan;} mdl_t;
    mdl_t ma, mb;
    int ncmp = 0, nerr = 0, nwrap, guard;

    function automatic mdl_t mstep(mdl_t s, int n);
        mdl_t r = s;
        r.wrap = 0;
        if (rst) begin
            r.y = 0; r.ch = 0; r.vld = 0; r.age = 0; r.scan = 0;
        end else if (!mode) begin
            r.scan = 0; r.age = 0;
            if (int'(sel) < n) begin r.y = dat[sel]; r.ch = sel; r.vld = 1; end
            else begin r.y = 0; r.vld = 0; end
        end else begin
            if (s.scan && s.age == DW) begin
                r.ch = (s.ch + 1) % n;
                r.wrap = (r.ch == 0);
                r.age = 1;
            end else begin
                r.age = s.scan ? s.age + 1 : 1;
            end
            r.scan = 1; r.y = dat[r.ch]; r.vld = 1;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        ma = mstep(ma, 8);
        mb = mstep(mb, 6);
        #1;
        chk("a_y", 32'(ya), ma.y);     chk("a_ch", 32'(cha), ma.ch);
        chk("a_vld", 32'(va), ma.vld); chk("a_wrap", 32'(wa), ma.wrap);
        chk("b_y", 32'(yb), mb.y);     chk("b_ch", 32'(chb), mb.ch);
        chk("b_vld", 32'(vb), mb.vld); chk("b_wrap", 32'(wb), mb.wrap);
    endtask

    task automatic fixed_data();
        for (int k = 0; k < 8; k++) dat[k] = 8'(8'h10 + k);
    endtask

    initial begin
        ma = '{0, 0, 0, 0, 0, 1'b0};
        mb = '{0, 0, 0, 0, 0, 1'b0};
        fixed_data();

        // 1. reset then manual sel=5
        rst = 1; mode = 0; sel = 5;
        tick(); chk("rst_y", 32'(ya), 0); chk("rst_vld", 32'(va), 0);
        tick();
        rst = 0;
        tick(); chk("man_y", 32'(ya), 32'h15); chk("man_ch", 32'(cha), 5); chk("man_vld", 32'(va), 1);

        // 2. scan from 0 for 40 cycles
        rst = 1; mode = 1; tick();
        rst = 0; nwrap = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("scan_ch", 32'(cha), (i / DW) % 8);
            chk("scan_wrap", 32'(wa), (i == 32) ? 1 : 0);
            chk("scan_y", 32'(ya), 32'h10 + (i / DW) % 8);
            nwrap += int'(wa);
        end
        chk("wrap_count", nwrap, 1);

        // 3. mode switch: scan at 3 for 2 cycles, manual sel=6, scan again
        mode = 0; sel = 3; tick();
        mode = 1; tick(); tick();
        chk("sw_hold3", 32'(cha), 3);
        mode = 0; sel = 6; tick();
        chk("sw_y", 32'(ya), 32'h16); chk("sw_ch", 32'(cha), 6);
        mode = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("sw_dwell", 32'(cha), (i < DW) ? 6 : 7);
        end

        // 4. reset mid-scan at ch=5, third cycle of its dwell
        guard = 0;
        while (!(ma.ch == 5 && ma.age == 3) && guard < 100) begin tick(); guard++; end
        chk("reach_ch5", (guard < 100) ? 1 : 0, 1);
        rst = 1; tick();
        chk("mid_rst_y", 32'(ya), 0); chk("mid_rst_ch", 32'(cha), 0);
        chk("mid_rst_vld", 32'(va), 0); chk("mid_rst_wrap", 32'(wa), 0);
        rst = 0; tick();
        chk("restart_ch", 32'(cha), 0); chk("restart_vld", 32'(va), 1);

        // 5. out-of-range select on the N=6 instance
        mode = 0; sel = 2; tick();
        sel = 7; tick();
        chk("oor_y", 32'(yb), 0); chk("oor_vld", 32'(vb), 0); chk("oor_ch", 32'(chb), 2);
        chk("inr_a_y", 32'(ya), 32'h17);
        sel = 2; tick();
        chk("back_y", 32'(yb), 32'h12); chk("back_vld", 32'(vb), 1);

        // random phase: live data, sticky mode, occasional reset
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 8; k++) dat[k] = 8'($urandom);
            if ($urandom_range(0, 11) == 0) mode = ~mode;
            sel = 3'($urandom_range(0, 7));
            rst = ($urandom_range(0, 59) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
